mem_io_ctrl: RTL

//  Parametrised SLC-3 memory/IO controller: next generation of the Mem2IO + tristate pair.

---
 rtl/mem_io_ctrl_if.sv | 24 ++
 rtl/mem_io_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl_if.sv
// CPU-side bus of the SLC-3 memory/IO controller: one load/store in flight at a time.
// Handshake: master raises cpu_req with cpu_we/cpu_addr/cpu_wdata and keeps req high until it sees
// the one-cycle cpu_ack pulse; the slave latches the command on the accepting edge, so cmd changes after that are ignored.
interface mem_io_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/mem_io_ctrl.sv
// SLC-3 memory/IO controller: sequences one CPU load/store onto async SRAM with WAIT_CYC access
// cycles, or services the single memory-mapped IO address (synchronised switches / hex display).
module mem_io_ctrl #(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 16,
  parameter int                 SRAM_ADDR_W = 20,
  parameter int                 WAIT_CYC    = 2,
  parameter int                 NUM_HEX     = 4,
  parameter logic [ADDR_W-1:0]  IO_ADDR     = 16'hFFFF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  mem_io_ctrl_if.slave             bus,
  input  logic [DATA_W-1:0]        Switches,
  output logic [NUM_HEX*4-1:0]     hex_digits,
  output logic                     CE,
  output logic                     OE,
  output logic                     WE,
  output logic                     UB,
  output logic                     LB,
  output logic [SRAM_ADDR_W-1:0]   ADDR,
  output logic [DATA_W-1:0]        Data_out,
  output logic                     Data_oe,
  input  logic [DATA_W-1:0]        Data_in,
  output logic [2:0]               o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IO     = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [NUM_HEX*4-1:0]  r_hex;
  logic [DATA_W-1:0]     r_sw_meta;
  logic [DATA_W-1:0]     r_sw_sync;
  logic                  r_ack;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_data_oe;

  logic                  w_accept;
  logic                  w_we_eff;
  logic                  w_sram_nxt;
  logic                  w_ce_n_nxt;
  logic                  w_oe_n_nxt;
  logic                  w_we_n_nxt;
  logic                  w_data_oe_nxt;
  logic                  w_ack_nxt;

  assign w_accept = (r_state == S_IDLE) && bus.cpu_req;
  // Direction of the transaction the next state belongs to: fresh command on accept, latched otherwise.
  assign w_we_eff = (r_state == S_IDLE) ? bus.cpu_we : r_we;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cpu_req) begin
          w_state_nxt = (bus.cpu_addr == IO_ADDR) ? S_IO : S_SETUP;
        end
      end
      S_IO:    w_state_nxt = S_DONE;
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_cnt_nxt   = 4'(WAIT_CYC - 1);
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are computed from the next state so every pin comes straight from a flop.
  always_comb begin
    w_sram_nxt    = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_ce_n_nxt    = !w_sram_nxt;
    w_oe_n_nxt    = !(w_sram_nxt && !w_we_eff);
    w_we_n_nxt    = !((w_state_nxt == S_ACCESS) && w_we_eff);
    w_data_oe_nxt = w_we_eff && (w_sram_nxt ||
                    ((w_state_nxt == S_DONE) && (r_state == S_ACCESS)));
    w_ack_nxt     = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_hex     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_ack     <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sw_meta <= Switches;
      r_sw_sync <= r_sw_meta;
      r_ack     <= w_ack_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_data_oe <= w_data_oe_nxt;
      if (w_accept) begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
      if (r_state == S_IO) begin
        if (r_we) r_hex   <= r_wdata[NUM_HEX*4-1:0];
        else      r_rdata <= r_sw_sync;
      end
      if ((r_state == S_ACCESS) && (r_cnt == 4'd0) && !r_we) begin
        r_rdata <= Data_in;
      end
    end
  end

  assign bus.cpu_ack   = r_ack;
  assign bus.cpu_rdata = r_rdata;
  assign hex_digits    = r_hex;
  assign CE            = r_ce_n;
  assign OE            = r_oe_n;
  assign WE            = r_we_n;
  assign UB            = r_ce_n;
  assign LB            = r_ce_n;
  assign ADDR          = SRAM_ADDR_W'(r_addr);
  assign Data_out      = r_wdata;
  assign Data_oe       = r_data_oe;
  assign o_dbg_state   = r_state;

endmodule
